bitmanip_mc_arbiter: RTL

//  Shares one multi-cycle bit-manipulation unit (start/busy/done, rs1/rs2 -> rd; e.g. tinygzip) between NREQ requesters.
//  Per-requester valid/ready request and response channels; round-robin grant; one operation in flight at a time.

---
 rtl/bitmanip_mc_pkg.sv | 13 +
 rtl/bitmanip_mc_arbiter_rr.sv | 30 +++
 rtl/bitmanip_mc_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/bitmanip_mc_pkg.sv
// Shared types for the multi-cycle bitmanip unit arbiter.
// Operand widths and the controller state encoding.
package bitmanip_mc_pkg;
  localparam int XLEN  = 32;
  localparam int RS2_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;
endpackage

// File: rtl/bitmanip_mc_arbiter_rr.sv
// Round-robin picker: first eligible requester at or after ptr.
// Purely combinational; the pointer lives in the caller.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);
  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && eligible[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = PW'(j);
      end
    end
  end
endmodule

// File: rtl/bitmanip_mc_arbiter.sv
// Shares one start/busy/done bitmanip unit among NREQ requesters,
// with per-requester response slots and a watchdog on the unit.
module bitmanip_mc_arbiter
  import bitmanip_mc_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*XLEN-1:0]  req_rs1,
  input  logic [NREQ*RS2_W-1:0] req_rs2,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [NREQ*XLEN-1:0]  resp_rd,
  output logic [NREQ-1:0]       resp_err,
  output logic                  unit_start,
  output logic [XLEN-1:0]       unit_rs1,
  output logic [RS2_W-1:0]      unit_rs2,
  input  logic [XLEN-1:0]       unit_rd,
  input  logic                  unit_busy,
  input  logic                  unit_done
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  state_t            state, nstate;
  logic [PW-1:0]     ptr, owner, gidx;
  logic [NREQ-1:0]   eligible, gnt;
  logic              any, take, fin_ok, fin_to;
  logic [XLEN-1:0]   rs1_q;
  logic [RS2_W-1:0]  rs2_q;
  logic [WW-1:0]     wd;

  assign eligible = req_valid & ~resp_valid;

  rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (gnt),
    .idx      (gidx),
    .any      (any)
  );

  // reset gating keeps req_ready low while reset is held
  assign take = (state == IDLE) & ~unit_busy & any & ~reset;
  assign req_ready = take ? gnt : '0;

  assign fin_ok = (state == WAIT) & unit_done;
  assign fin_to = (state == WAIT) & ~unit_done
                & (wd == WW'(TIMEOUT - 1));

  assign unit_start = (state == START);
  assign unit_rs1   = unit_start ? rs1_q : '0;
  assign unit_rs2   = unit_start ? rs2_q : '0;

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:  if (take) nstate = START;
      START: nstate = WAIT;
      WAIT: begin
        if (fin_ok)      nstate = IDLE;
        else if (fin_to) nstate = DRAIN;
      end
      DRAIN: if (!unit_busy && !unit_done) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      wd    <= '0;
    end else begin
      state <= nstate;
      if (take) begin
        owner <= gidx;
        rs1_q <= req_rs1[XLEN*gidx +: XLEN];
        rs2_q <= req_rs2[RS2_W*gidx +: RS2_W];
        ptr   <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
      end
      if (state == START) begin
        wd <= '0;
      end else if (state == WAIT && wd != WW'(TIMEOUT)) begin
        wd <= wd + 1'b1;
      end
    end
  end

  // owner's slot is always empty while its op is in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_valid <= '0;
      resp_rd    <= '0;
      resp_err   <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if ((fin_ok || fin_to) && owner == PW'(i)) begin
          resp_valid[i]           <= 1'b1;
          resp_err[i]             <= fin_to;
          resp_rd[XLEN*i +: XLEN] <= fin_ok ? unit_rd : '0;
        end else if (resp_valid[i] && resp_ready[i]) begin
          resp_valid[i] <= 1'b0;
        end
      end
    end
  end
endmodule
